// File: rtl/gray_code_counter_pkg.sv
// Shared Gray/binary helpers and count bounds for the Gray-code counter family.
// The helpers work on 32-bit containers and mask to the requested width, so
// one definition serves every counter width from 2 to 32.
package gray_code_counter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    // Mask keeping the low 'width' bits; saturates at 32 bits.
    function automatic logic [31:0] width_mask(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    // Largest count representable in 'width' bits.
    function automatic logic [31:0] count_max(input int unsigned width);
        return width_mask(width);
    endfunction

    localparam logic [31:0] MAX = count_max(WIDTH_DEFAULT);
    localparam logic [31:0] MIN = 32'd0;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
        logic [31:0] bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
        logic [31:0] gm;
        logic [31:0] b;
        gm    = g & width_mask(width);
        b     = '0;
        b[31] = gm[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_gray_to_bin_n.sv
// Purely combinational WIDTH-bit Gray-to-binary converter.
module gray_to_bin_n
    import gray_code_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(32'(gray), WIDTH));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down Gray-code counter with synchronous load, wrap or saturate at the
// ends, and a registered terminal-count flag. The count is kept in binary;
// the Gray output is registered in lockstep so no input reaches an output
// combinationally.
module gray_code_counter
    import gray_code_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(count_max(WIDTH));
    localparam logic [WIDTH-1:0] CNT_MIN = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             tc_d;

    gray_to_bin_n #(
        .WIDTH(WIDTH)
    ) u_load_conv (
        .gray(load_gray),
        .bin (load_bin)
    );

    // Next count: load beats enable; at an end either wrap or stick.
    always_comb begin
        bin_d  = bin;
        gray_d = gray;
        tc_d   = tc;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_gray;
        end else if (en) begin
            if (up) begin
                bin_d = (bin == CNT_MAX) ? (WRAP ? CNT_MIN : CNT_MAX) : bin + CNT_ONE;
            end else begin
                bin_d = (bin == CNT_MIN) ? (WRAP ? CNT_MAX : CNT_MIN) : bin - CNT_ONE;
            end
            gray_d = WIDTH'(bin2gray(32'(bin_d), WIDTH));
        end
        // tc only re-evaluates on edges that move or load the count; idle edges keep it.
        if (load || en) begin
            tc_d = up ? (bin_d == CNT_MAX) : (bin_d == CNT_MIN);
        end
    end

    // Output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            tc   <= 1'b0;
        end else begin
            bin  <= bin_d;
            gray <= gray_d;
            tc   <= tc_d;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench: three counters (4-bit wrap, 4-bit saturate, 8-bit
// saturate) checked every cycle against an arithmetic model, plus directed
// vectors with hand-computed values.
module tb_gray_code_counter;
    import gray_code_counter_pkg::*;

    logic clk;
    logic rst_n_a, rst_n_bc;

    logic       en_a, up_a, load_a;
    logic [3:0] lg_a, gray_a, bin_a;
    logic       tc_a;
    logic       en_b, up_b, load_b;
    logic [3:0] lg_b, gray_b, bin_b;
    logic       tc_b;
    logic       en_c, up_c, load_c;
    logic [7:0] lg_c, gray_c, bin_c;
    logic       tc_c;

    int nchk = 0;
    int nerr = 0;
    bit cmp_on = 0;

    longint unsigned ma_cnt, mb_cnt, mc_cnt;
    bit              ma_tc, mb_tc, mc_tc;

    gray_code_counter #(.WIDTH(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .up(up_a), .load(load_a),
        .load_gray(lg_a), .gray(gray_a), .bin(bin_a), .tc(tc_a)
    );
    gray_code_counter #(.WIDTH(4), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_bc), .en(en_b), .up(up_b), .load(load_b),
        .load_gray(lg_b), .gray(gray_b), .bin(bin_b), .tc(tc_b)
    );
    gray_code_counter #(.WIDTH(8), .WRAP(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n_bc), .en(en_c), .up(up_c), .load(load_c),
        .load_gray(lg_c), .gray(gray_c), .bin(bin_c), .tc(tc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Counter behaviour stated arithmetically.
    task automatic model_step(input int unsigned w, input bit wrap, input bit ld, input bit en,
                              input bit up, input logic [31:0] lg,
                              inout longint unsigned cnt, inout bit tc);
        longint unsigned top;
        top = (64'd1 << w) - 64'd1;
        if (ld) begin
            cnt = 64'(gray2bin(lg, w));
        end else if (en) begin
            if (up) cnt = (cnt == top) ? (wrap ? 64'd0 : top) : cnt + 64'd1;
            else    cnt = (cnt == 64'd0) ? (wrap ? top : 64'd0) : cnt - 64'd1;
        end
        if (ld || en) tc = up ? (cnt == top) : (cnt == 64'd0);
    endtask

    // Model for dut_a.
    always @(posedge clk or negedge rst_n_a) begin : mdl_a
        longint unsigned c;
        bit t;
        if (!rst_n_a) begin
            ma_cnt <= 0;
            ma_tc  <= 0;
        end else begin
            c = ma_cnt;
            t = ma_tc;
            model_step(4, 1'b1, load_a, en_a, up_a, 32'(lg_a), c, t);
            ma_cnt <= c;
            ma_tc  <= t;
        end
    end

    // Models for dut_b and dut_c.
    always @(posedge clk or negedge rst_n_bc) begin : mdl_bc
        longint unsigned c;
        bit t;
        if (!rst_n_bc) begin
            mb_cnt <= 0;
            mb_tc  <= 0;
            mc_cnt <= 0;
            mc_tc  <= 0;
        end else begin
            c = mb_cnt;
            t = mb_tc;
            model_step(4, 1'b0, load_b, en_b, up_b, 32'(lg_b), c, t);
            mb_cnt <= c;
            mb_tc  <= t;
            c = mc_cnt;
            t = mc_tc;
            model_step(8, 1'b0, load_c, en_c, up_c, 32'(lg_c), c, t);
            mc_cnt <= c;
            mc_tc  <= t;
        end
    end

    // Every-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("a_bin", 32'(bin_a), 32'(ma_cnt));
            check("a_gray", 32'(gray_a), bin2gray(32'(ma_cnt), 4));
            check("a_tc", 32'(tc_a), 32'(ma_tc));
            check("b_bin", 32'(bin_b), 32'(mb_cnt));
            check("b_gray", 32'(gray_b), bin2gray(32'(mb_cnt), 4));
            check("b_tc", 32'(tc_b), 32'(mb_tc));
            check("c_bin", 32'(bin_c), 32'(mc_cnt));
            check("c_gray_vs_bin", 32'(gray_c), bin2gray(32'(bin_c), 8));
            check("c_tc", 32'(tc_c), 32'(mc_tc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] gtab [17];
    logic [3:0] prev;

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                 4'b0000};
        {en_a, up_a, load_a, lg_a} = '0;
        {en_b, up_b, load_b, lg_b} = '0;
        {en_c, up_c, load_c, lg_c} = '0;
        rst_n_a  = 1'b0;
        rst_n_bc = 1'b0;

        // Pin the package helpers with hand-computed values.
        check("pkg_bin2gray_11", bin2gray(32'd11, 4), 32'hE);
        check("pkg_gray2bin_E", gray2bin(32'hE, 4), 32'hB);
        check("pkg_gray2bin_80", gray2bin(32'h80, 8), 32'hFF);

        #3;
        check("rst_bin", 32'(bin_a), 32'd0);
        check("rst_gray", 32'(gray_a), 32'd0);
        check("rst_tc", 32'(tc_a), 32'd0);
        tick();
        rst_n_a  = 1'b1;
        rst_n_bc = 1'b1;
        cmp_on   = 1'b1;

        // Full wrapping up-count.
        en_a = 1'b1;
        up_a = 1'b1;
        prev = gray_a;
        for (int i = 0; i < 17; i++) begin
            check("seq_gray", 32'(gray_a), 32'(gtab[i]));
            check("seq_tc", 32'(tc_a), (i == 15) ? 32'd1 : 32'd0);
            if (i > 0) check("seq_one_bit", $countones(gray_a ^ prev), 32'd1);
            prev = gray_a;
            tick();
        end

        // Load zero, then decrement wraps to the top.
        en_a = 1'b0; load_a = 1'b1; lg_a = 4'b0000;
        tick();
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
        tick();
        check("wrap_dn_bin", 32'(bin_a), 32'hF);
        check("wrap_dn_gray", 32'(gray_a), 32'h8);
        check("wrap_dn_tc", 32'(tc_a), 32'd0);

        // Load wins over an enabled count.
        load_a = 1'b1; lg_a = 4'b1110; en_a = 1'b1; up_a = 1'b1;
        tick();
        check("load_win_bin", 32'(bin_a), 32'hB);
        check("load_win_gray", 32'(gray_a), 32'hE);

        // Asynchronous reset mid-count.
        lg_a = 4'b0101;
        tick();
        check("pre_rst_bin", 32'(bin_a), 32'h6);
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        rst_n_a = 1'b0;
        #1;
        check("async_rst_bin", 32'(bin_a), 32'd0);
        check("async_rst_gray", 32'(gray_a), 32'd0);
        check("async_rst_tc", 32'(tc_a), 32'd0);
        #1;
        rst_n_a = 1'b1;
        tick();
        check("resume_bin", 32'(bin_a), 32'h1);
        check("resume_gray", 32'(gray_a), 32'h1);
        tick();
        check("resume2_gray", 32'(gray_a), 32'h3);
        en_a = 1'b0;

        // Saturation at the top, then reversal.
        load_b = 1'b1; lg_b = 4'b1000; up_b = 1'b1;
        tick();
        check("sat_load_bin", 32'(bin_b), 32'hF);
        check("sat_load_tc", 32'(tc_b), 32'd1);
        load_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_hold_bin", 32'(bin_b), 32'hF);
            check("sat_hold_tc", 32'(tc_b), 32'd1);
        end
        up_b = 1'b0;
        tick();
        check("sat_rev_bin", 32'(bin_b), 32'hE);
        check("sat_rev_gray", 32'(gray_b), 32'h9);
        check("sat_rev_tc", 32'(tc_b), 32'd0);

        // Saturation at zero, and tc held across an idle edge.
        load_b = 1'b1; lg_b = 4'b0001; en_b = 1'b0;
        tick();
        check("sat0_load_bin", 32'(bin_b), 32'h1);
        check("sat0_load_tc", 32'(tc_b), 32'd0);
        load_b = 1'b0; en_b = 1'b1;
        tick();
        check("sat0_bin", 32'(bin_b), 32'h0);
        check("sat0_tc", 32'(tc_b), 32'd1);
        tick();
        check("sat0_hold_bin", 32'(bin_b), 32'h0);
        check("sat0_hold_tc", 32'(tc_b), 32'd1);
        en_b = 1'b0;
        tick();
        check("idle_tc", 32'(tc_b), 32'd1);
        en_b = 1'b1; up_b = 1'b1;
        tick();
        check("leave0_bin", 32'(bin_b), 32'h1);
        check("leave0_tc", 32'(tc_b), 32'd0);
        en_b = 1'b0;

        // Random load/en/up traffic on the 8-bit counter.
        for (int i = 0; i < 2000; i++) begin
            load_c = ($urandom_range(0, 7) == 0);
            lg_c   = 8'($urandom_range(0, 255));
            en_c   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) up_c = ~up_c;
            tick();
        end
        load_c = 1'b0;
        en_c   = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
